// File: rtl/exe_mem_stage_reg_pkg.sv
// Shared widths, flag bit positions and the entry layout for the EXE/MEM boundary.
// The entry typedef uses the default widths; parameterised users build a local copy.
package exe_mem_stage_reg_pkg;

   localparam int DATA_W_DEF     = 32;
   localparam int REG_ADDR_W_DEF = 4;

   localparam int FLAGS_W = 4;
   localparam int FLAG_N  = 3;
   localparam int FLAG_Z  = 2;
   localparam int FLAG_C  = 1;
   localparam int FLAG_V  = 0;

   typedef struct packed {
      logic [DATA_W_DEF-1:0]     result;
      logic [DATA_W_DEF-1:0]     store_data;
      logic [REG_ADDR_W_DEF-1:0] dest;
      logic                      wb_en;
      logic                      r_en;
      logic                      w_en;
   } mem_entry_t;

   // Carry-in seen by the ALU for ADC/SBC-style instructions.
   function automatic logic carry_in(input logic [FLAGS_W-1:0] flags);
      return flags[FLAG_C];
   endfunction

endpackage

// File: rtl/exe_mem_stage_reg_if.sv
// EXE-side and MEM-side bundle of the EXE/MEM pipeline register.
// slave: the stage register itself; master: the surrounding pipeline (or a bench).
interface exe_mem_stage_reg_if
   import exe_mem_stage_reg_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) ();

   logic                  exe_valid;
   logic                  exe_ready;
   logic [DATA_W-1:0]     alu_result;
   logic [FLAGS_W-1:0]    alu_status;
   logic                  s_bit;
   logic [DATA_W-1:0]     store_data;
   logic [REG_ADDR_W-1:0] dest;
   logic                  wb_en;
   logic                  mem_r_en;
   logic                  mem_w_en;
   logic                  flush;

   logic                  mem_valid;
   logic                  mem_ready;
   logic [DATA_W-1:0]     mem_alu_result;
   logic [DATA_W-1:0]     mem_store_data;
   logic [REG_ADDR_W-1:0] mem_dest;
   logic                  mem_wb_en;
   logic                  mem_r_en_o;
   logic                  mem_w_en_o;
   logic [FLAGS_W-1:0]    status_out;

   modport slave (
      input  exe_valid, alu_result, alu_status, s_bit, store_data, dest,
             wb_en, mem_r_en, mem_w_en, flush, mem_ready,
      output exe_ready, mem_valid, mem_alu_result, mem_store_data, mem_dest,
             mem_wb_en, mem_r_en_o, mem_w_en_o, status_out
   );

   modport master (
      output exe_valid, alu_result, alu_status, s_bit, store_data, dest,
             wb_en, mem_r_en, mem_w_en, flush, mem_ready,
      input  exe_ready, mem_valid, mem_alu_result, mem_store_data, mem_dest,
             mem_wb_en, mem_r_en_o, mem_w_en_o, status_out
   );

endinterface

// File: rtl/exe_mem_stage_reg_status_reg.sv
// Architectural {N,Z,C,V} register with load enable and asynchronous reset.
// Also used by the decode-stage condition check.
module status_reg
   import exe_mem_stage_reg_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [FLAGS_W-1:0] flags_in,
   output logic [FLAGS_W-1:0] flags_out
);

   logic [FLAGS_W-1:0] flags_d;
   logic [FLAGS_W-1:0] flags_q;

   always_comb begin
      flags_d = flags_q;
      if (load) begin
         flags_d = flags_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign flags_out = flags_q;

endmodule

// File: rtl/exe_mem_stage_reg.sv
// EXE->MEM pipeline register with flush, MEM backpressure and the status register.
// Define EXE_MEM_SKID_EN for a 2-entry skid buffer with a registered exe_ready.
module exe_mem_stage_reg
   import exe_mem_stage_reg_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   exe_mem_stage_reg_if.slave  bus
);

   typedef struct packed {
      logic [DATA_W-1:0]     result;
      logic [DATA_W-1:0]     store_data;
      logic [REG_ADDR_W-1:0] dest;
      logic                  wb_en;
      logic                  r_en;
      logic                  w_en;
   } entry_t;

   entry_t             in_entry;
   entry_t             main_d;
   entry_t             main_q;
   logic               main_valid_d;
   logic               main_valid_q;
   logic               ready;
   logic               accept;
   logic               pop;
   logic [FLAGS_W-1:0] status_flags;

   always_comb begin
      in_entry.result     = bus.alu_result;
      in_entry.store_data = bus.store_data;
      in_entry.dest       = bus.dest;
      in_entry.wb_en      = bus.wb_en;
      in_entry.r_en       = bus.mem_r_en;
      in_entry.w_en       = bus.mem_w_en;
   end

   // Flush suppresses the accept, so a discarded entry never touches the flags.
   assign accept = bus.exe_valid & ready & ~bus.flush;
   assign pop    = main_valid_q & bus.mem_ready;

`ifdef EXE_MEM_SKID_EN
   entry_t skid_d;
   entry_t skid_q;
   logic   skid_valid_d;
   logic   skid_valid_q;

   assign ready = ~skid_valid_q;

   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (pop) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
         end else begin
            main_valid_d = 1'b0;
         end
      end
      // After the pop step, a still-valid main slot means the newcomer queues behind it.
      if (accept) begin
         if (!main_valid_d) begin
            main_d       = in_entry;
            main_valid_d = 1'b1;
         end else begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
         end
      end
      if (bus.flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q       <= '0;
         main_valid_q <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         main_valid_q <= main_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end
`else
   assign ready = ~main_valid_q | bus.mem_ready;

   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      if (pop) begin
         main_valid_d = 1'b0;
      end
      if (accept) begin
         main_d       = in_entry;
         main_valid_d = 1'b1;
      end
      if (bus.flush) begin
         main_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q       <= '0;
         main_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         main_valid_q <= main_valid_d;
      end
   end
`endif

   status_reg u_status_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (accept & bus.s_bit),
      .flags_in  (bus.alu_status),
      .flags_out (status_flags)
   );

   assign bus.exe_ready      = ready;
   assign bus.status_out     = status_flags;
   assign bus.mem_valid      = main_valid_q;
   assign bus.mem_alu_result = main_q.result;
   assign bus.mem_store_data = main_q.store_data;
   assign bus.mem_dest       = main_q.dest;
   assign bus.mem_wb_en      = main_q.wb_en & main_valid_q;
   assign bus.mem_r_en_o     = main_q.r_en  & main_valid_q;
   assign bus.mem_w_en_o     = main_q.w_en  & main_valid_q;

endmodule

// File: doc/exe_mem_stage_reg.md
Name: exe_mem_stage_reg

Overview:
- Pipeline boundary between the execute stage (ALU) and the memory stage.
- Captures the ALU result, the ALU NZCV flags, store data and control bits on a valid/ready handshake.
- Owns the architectural status register, which is updated by flag-setting instructions and fed back to the ALU carry-in and condition check.
- Supports flush (taken branch) and downstream backpressure (memory stall).

Parameters:
DATA_W, 32, width of ALU result and store data
REG_ADDR_W, 4, width of destination register index

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
exe_valid  input  1  EXE presents a valid instruction
exe_ready  output  1  block can accept this cycle
alu_result  input  DATA_W  ALU result
alu_status  input  4  ALU flags {N,Z,C,V}
s_bit  input  1  instruction updates status register
store_data  input  DATA_W  Rm value for STR
dest  input  REG_ADDR_W  writeback register index
wb_en  input  1  writeback enable
mem_r_en  input  1  load
mem_w_en  input  1  store
flush  input  1  discard all held and incoming entries
mem_valid  output  1  head entry valid toward MEM
mem_ready  input  1  MEM consumes head entry this cycle
mem_alu_result  output  DATA_W  head entry result
mem_store_data  output  DATA_W  head entry store data
mem_dest  output  REG_ADDR_W  head entry destination
mem_wb_en  output  1  head entry writeback enable (0 when !mem_valid)
mem_r_en_o  output  1  head entry load (0 when !mem_valid)
mem_w_en_o  output  1  head entry store (0 when !mem_valid)
status_out  output  4  architectural {N,Z,C,V} to ALU status_in and condition check

Behaviour:
- Reset (async, rst=1): all entries invalid, all data outputs 0, status_out=4'b0000, exe_ready=1.
- Accept: exe_valid & exe_ready & !flush at posedge; the entry appears on mem_* the next cycle (latency 1).
- Consume: mem_valid & mem_ready at posedge pops the head.
- Storage: 2-entry skid buffer (main + skid) when the feature is enabled.
  - exe_ready = !skid_valid (registered, no combinational path from mem_ready).
  - Accept while the head is held and not consumed: the entry goes to the skid slot.
  - Pop with skid occupied: skid moves to main.
  - Simultaneous accept and pop: the new entry goes to main if skid is empty, else skid->main and the new entry -> skid.
- Order is strictly FIFO; entries are never duplicated or dropped except by flush.
- Full (both slots valid): exe_ready=0; exe_valid ignored.
- Empty: mem_valid=0; control outputs forced 0; data outputs hold their last value.
- Flush: at posedge, both slots invalidated and any same-cycle accept discarded (flush wins). The status register is not updated by a discarded entry. A pop in the same cycle still completes from MEM's view.
- Status register: loads alu_status at posedge on accept when s_bit=1; otherwise holds. Updated at accept time, not pop time, so the next instruction in EXE sees the flags one cycle later.
- Back-to-back S instructions: each accepted one overwrites in order.
- Control outputs (wb_en, r_en, w_en) are gated by head valid.

Optional Feature:
- Macro: EXE_MEM_SKID_EN.
- Defined: 2-entry skid buffer as above; exe_ready is registered.
- Undefined: single entry.
  - exe_ready = !main_valid | mem_ready (combinational from mem_ready).
  - Accept and pop in the same cycle replaces the entry.
  - Flush and status rules unchanged.

Decomposition:
- Shared package: DATA_W and REG_ADDR_W defaults; flag bit indices N=3, Z=2, C=1, V=0; a packed entry typedef {result, store_data, dest, wb_en, r_en, w_en}.
- One sub-module: status_reg (4-bit flag register with load enable and async reset), reused by the decode-stage condition check.

Test Plan:
- Reset mid-transfer: two entries held, assert rst -> mem_valid=0, status_out=0, exe_ready=1 immediately (async).
- Single pass: accept result=32'h0000_0005, dest=3, wb_en=1, mem_ready=1 -> next cycle mem_valid=1, mem_alu_result=5, mem_dest=3, mem_wb_en=1.
- Backpressure: mem_ready=0, push A=1, B=2 -> exe_ready=0 after B. Then mem_ready=1 -> outputs 1 then 2 on consecutive cycles, exe_ready=1 again.
- Status update: accept ADDS with alu_status=4'b0110, s_bit=1 -> status_out=4'b0110. Next accept with s_bit=0 and alu_status=4'b1001 -> status_out stays 4'b0110.
- Flush priority: flush=1 with exe_valid=1, s_bit=1, alu_status=4'b1000, one entry held -> next cycle mem_valid=0, status_out unchanged.
- Feature off: mem_ready=1 continuously, exe_valid each cycle -> one entry accepted per cycle, exe_ready stays 1, values emerge in order.
